core_sequencer_r32i: RTL and testbench
======================================

Name: core_sequencer_r32i

Overview:
- Multi-cycle control FSM for the RV32I single-issue datapath.
- Sequences fetch, decode, execute, memory and writeback around the instruction decoder, ALU, register file, PC and RAM.
- Consumes the decoder's control flags; produces one-cycle enables for the instruction register, register file, PC and data RAM.
- Owns the instruction-memory and data-memory req/ack handshakes, with a bus timeout.

Parameters:
- dataW, 32, datapath width; also the width of InstrIn and RetireCount.
- MaxWait, 255, max cycles a memory request waits for ack before fault; legal range 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- RunEnable  in  1  permits leaving IDLE and starting the next instruction.
- IMemReq  out  1  instruction fetch request.
- IMemAck  in  1  instruction memory ack; InstrIn valid in the same cycle.
- InstrIn  in  dataW  fetched instruction word.
- InstrReg  out  dataW  registered instruction; drives the decoder rawIns.
- RegWriteControl  in  1  decoder flag.
- RAMWriteControl  in  1  decoder flag.
- RAMRead  in  1  decoder flag.
- TestBranch  in  1  decoder flag.
- AlwaysBranch  in  1  decoder flag.
- BranchCond  in  1  condition-generator result.
- DMemReq  out  1  data RAM request.
- DMemWe  out  1  data RAM write strobe, qualified by DMemReq.
- DMemAck  in  1  data RAM ack.
- RegWriteEn  out  1  register file write enable.
- PCUpdate  out  1  PC register load.
- PCTakeBranch  out  1  PC mux select: branch target (1) or PC+4 (0); valid with PCUpdate.
- BusFault  out  1  sticky timeout fault.
- State  out  3  current FSM state, for debug.

Behaviour:
- Reset: asynchronous, active-high. Forces state IDLE, InstrReg=0, wait counter=0, BusFault=0. All outputs read 0 while reset is held and in the cycle after release.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, FAULT.
- IDLE: all strobes low. Go to FETCH when RunEnable=1.
- FETCH: IMemReq=1.
  - If IMemAck=1: InstrReg<=InstrIn on that edge; go to DECODE.
  - Otherwise hold and increment the wait counter.
- DECODE: one cycle for decoder outputs to settle from InstrReg; no strobes.
- EXECUTE: one cycle for ALU settle.
  - isMem = RAMWriteControl | (RAMRead & RegWriteControl). A store asserts RAMRead as well, so RAMWriteControl takes priority.
  - isMem=1: go to MEM. isMem=0: go to WRITEBACK.
- MEM: DMemReq=1, DMemWe=RAMWriteControl.
  - On DMemAck=1: go to WRITEBACK.
  - Otherwise hold and increment the wait counter.
  - Load data is captured externally on the ack cycle.
- WRITEBACK: exactly one cycle.
  - RegWriteEn=RegWriteControl. A store never writes, because the decoder deasserts RegWriteControl for stores.
  - PCUpdate=1; PCTakeBranch = AlwaysBranch | (TestBranch & BranchCond).
  - Next state: FETCH if RunEnable=1, else IDLE.
- Wait counter: clog2(MaxWait+1) bits; cleared on entry to FETCH or MEM.
  - If the counter equals MaxWait and no ack arrives in that cycle, go to FAULT.
  - An ack in the same cycle as the limit wins: normal transition, no fault.
- FAULT: BusFault=1, all strobes low. Leaves only on reset.
- Latency: zero-wait memory gives 4 cycles per non-memory instruction (FETCH, DECODE, EXECUTE, WRITEBACK) and 5 for load/store. Each ack wait cycle adds 1.
- Decoder flags are sampled only in EXECUTE, MEM and WRITEBACK; InstrReg is stable in those states.
- Unknown opcodes decode to all-zero flags and retire as a NOP: PCUpdate=1, PCTakeBranch=0.
- RunEnable deasserted mid-instruction: the instruction completes, then the FSM enters IDLE.
- Reset mid-handshake: the request drops immediately; a late ack in IDLE is ignored.
- Outputs are combinational decodes of the state register plus listed inputs only; no combinational path from IMemAck or DMemAck to IMemReq or DMemReq.

Optional Feature:
- Macro: SEQ_RETIRE_COUNT_EN.
- With the macro defined:
  - Adds output RetireCount [dataW-1:0], reset to 0.
  - Increments by 1 on every WRITEBACK cycle and wraps from all-ones to 0.
  - Holds during IDLE and FAULT.
- Without the macro: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package seq_pkg:
  - seq_state_t enum, 3-bit, with encodings IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, FAULT=6.
  - Default MaxWait localparam.
- Sub-module bus_wait_timer: clear/enable inputs, `expired` output, parameterised by MaxWait. One instance, shared by FETCH and MEM since they are mutually exclusive.

Test Plan:
1. ADDI (0x00500093), IMemAck on the first FETCH cycle, RunEnable=1 → states 1,2,3,5; RegWriteEn=1 and PCUpdate=1 in cycle 4; PCTakeBranch=0; back to FETCH in cycle 5.
2. SW (0x00112223) with DMemAck 2 cycles late → MEM lasts 3 cycles with DMemReq=DMemWe=1; WRITEBACK has RegWriteEn=0; 7 cycles total.
3. BEQ with BranchCond=1, then again with BranchCond=0 → PCTakeBranch=1 then 0 in WRITEBACK; RegWriteEn=0 in both.
4. MaxWait=4, IMemAck held low → FAULT entered after 5 FETCH cycles; BusFault=1 sticky; IMemReq=0; only reset clears it.
5. Assert reset asynchronously mid-MEM → DMemReq falls before the next clock edge; State=IDLE; RunEnable=0 keeps the FSM in IDLE.
6. SEQ_RETIRE_COUNT_EN defined, RetireCount forced to 0xFFFFFFFF, one LUI retired → RetireCount=0.

Source files
------------

// File: rtl/core_sequencer_r32i_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared types and defaults for the RV32I multi-cycle sequencer.
//   seq_state_t      : 3-bit FSM state encoding, also exported on the State port
//   DEFAULT_MAX_WAIT : default memory-ack timeout in cycles
// -----------------------------------------------------------------------------
package seq_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      DECODE    = 3'd2,
      EXECUTE   = 3'd3,
      MEM       = 3'd4,
      WRITEBACK = 3'd5,
      FAULT     = 3'd6
   } seq_state_t;

   localparam int unsigned DEFAULT_MAX_WAIT = 255;

endpackage : seq_pkg

// File: rtl/core_sequencer_r32i_bus_wait_timer.sv
// -----------------------------------------------------------------------------
// bus_wait_timer
// Counts cycles a memory request has been waiting for its ack.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the counter (held while no request is outstanding)
//   enable     : count one more wait cycle (request up, no ack this cycle)
//   expired    : counter has reached MaxWait
// One instance serves both FETCH and MEM, which never overlap.
// -----------------------------------------------------------------------------
module bus_wait_timer #(
   parameter int unsigned MaxWait = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CntW = $clog2(MaxWait + 1);

   logic [CntW-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (clear)       count_d = '0;
      else if (enable) count_d = count_q + CntW'(1);
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge value of its neighbours regardless of process order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign expired = (count_q == CntW'(MaxWait));

endmodule : bus_wait_timer

// File: rtl/core_sequencer_r32i.sv
// -----------------------------------------------------------------------------
// core_sequencer_r32i
// Multi-cycle control FSM for the RV32I single-issue datapath:
// IDLE -> FETCH -> DECODE -> EXECUTE -> [MEM] -> WRITEBACK -> FETCH/IDLE,
// with a sticky FAULT state on memory-ack timeout.
//   clk, reset          : clock, asynchronous active-high reset
//   RunEnable           : permits starting the next instruction
//   IMemReq/IMemAck     : instruction fetch handshake, InstrIn valid with ack
//   InstrReg            : registered instruction feeding the decoder
//   RegWriteControl, RAMWriteControl, RAMRead, TestBranch, AlwaysBranch,
//   BranchCond          : decoder / condition flags, sampled in EXECUTE..WRITEBACK
//   DMemReq/DMemWe/DMemAck : data RAM handshake
//   RegWriteEn, PCUpdate, PCTakeBranch : one-cycle WRITEBACK strobes
//   BusFault            : sticky timeout indication
//   State               : current FSM state (debug)
//   RetireCount         : retired-instruction counter, present only when
//                         SEQ_RETIRE_COUNT_EN is defined
// -----------------------------------------------------------------------------
module core_sequencer_r32i
   import seq_pkg::*;
#(
   parameter int unsigned dataW   = 32,
   parameter int unsigned MaxWait = DEFAULT_MAX_WAIT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             RunEnable,
   output logic             IMemReq,
   input  logic             IMemAck,
   input  logic [dataW-1:0] InstrIn,
   output logic [dataW-1:0] InstrReg,
   input  logic             RegWriteControl,
   input  logic             RAMWriteControl,
   input  logic             RAMRead,
   input  logic             TestBranch,
   input  logic             AlwaysBranch,
   input  logic             BranchCond,
   output logic             DMemReq,
   output logic             DMemWe,
   input  logic             DMemAck,
   output logic             RegWriteEn,
   output logic             PCUpdate,
   output logic             PCTakeBranch,
   output logic             BusFault,
`ifdef SEQ_RETIRE_COUNT_EN
   output logic [dataW-1:0] RetireCount,
`endif
   output logic [2:0]       State
);

   seq_state_t       state_d, state_q;
   logic [dataW-1:0] instr_reg_d, instr_reg_q;
   logic             wait_clear, wait_enable, wait_expired;
   logic             is_mem;

   // A store also raises RAMRead; RAMWriteControl alone is enough to mark it.
   assign is_mem = RAMWriteControl | (RAMRead & RegWriteControl);

   // Counter stays cleared outside the two waiting states, so it is zero on
   // every entry to FETCH or MEM.
   assign wait_clear  = (state_q != FETCH) && (state_q != MEM);
   assign wait_enable = ((state_q == FETCH) && !IMemAck) ||
                        ((state_q == MEM)   && !DMemAck);

   bus_wait_timer #(.MaxWait(MaxWait)) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (wait_clear),
      .enable  (wait_enable),
      .expired (wait_expired)
   );

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: the instruction register is reset too, so the decoder sees a
      // defined all-zero word before the first fetch.
      if (reset) begin
         state_q     <= IDLE;
         instr_reg_q <= '0;
      end else begin
         state_q     <= state_d;
         instr_reg_q <= instr_reg_d;
      end
   end

   // ---------------- next-state logic ----------------
   // NOTE: every always_comb output gets a default first, so no path through
   // the case can leave it unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      instr_reg_d = instr_reg_q;
      unique case (state_q)
         IDLE:      if (RunEnable) state_d = FETCH;
         FETCH: begin
            // An ack arriving on the limit cycle still wins over the timeout.
            if (IMemAck) begin
               state_d     = DECODE;
               instr_reg_d = InstrIn;
            end else if (wait_expired) begin
               state_d = FAULT;
            end
         end
         DECODE:    state_d = EXECUTE;
         EXECUTE:   state_d = is_mem ? MEM : WRITEBACK;
         MEM: begin
            if (DMemAck)           state_d = WRITEBACK;
            else if (wait_expired) state_d = FAULT;
         end
         WRITEBACK: state_d = RunEnable ? FETCH : IDLE;
         FAULT:     state_d = FAULT;
         default:   state_d = IDLE;
      endcase
   end

   // ---------------- output decode ----------------
   // Requests depend on the state register only: no ack-to-request path.
   always_comb begin
      IMemReq      = (state_q == FETCH);
      DMemReq      = (state_q == MEM);
      DMemWe       = (state_q == MEM) && RAMWriteControl;
      RegWriteEn   = (state_q == WRITEBACK) && RegWriteControl;
      PCUpdate     = (state_q == WRITEBACK);
      PCTakeBranch = (state_q == WRITEBACK) && (AlwaysBranch || (TestBranch && BranchCond));
      BusFault     = (state_q == FAULT);
   end

   assign InstrReg = instr_reg_q;
   assign State    = state_q;

`ifdef SEQ_RETIRE_COUNT_EN
   logic [dataW-1:0] retire_count_d, retire_count_q;

   always_comb begin
      retire_count_d = retire_count_q;
      if (state_q == WRITEBACK) retire_count_d = retire_count_q + dataW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) retire_count_q <= '0;
      else       retire_count_q <= retire_count_d;
   end

   assign RetireCount = retire_count_q;
`endif

endmodule : core_sequencer_r32i

// File: tb/tb_core_sequencer_r32i.sv
// -----------------------------------------------------------------------------
// tb_core_sequencer_r32i
// Randomised instruction stream with random memory ack latencies; a
// reference model derives each instruction's expected retire behaviour from
// its instruction class and pushes it to a queue, and an independent monitor
// pops and compares whenever the DUT retires (PCUpdate). Directed tails cover
// reset mid-MEM and the fetch timeout (MaxWait = 4).
// -----------------------------------------------------------------------------
module tb_core_sequencer_r32i;

   localparam int MAX_WAIT = 4;

   typedef enum int {C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_NOP} iclass_t;

   typedef struct {
      logic [31:0] instr;
      bit          reg_we;
      bit          take;
      bit          is_mem;
      bit          we;
      int          cycles;
      int          mem_cycles;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        RunEnable = 1'b0;
   logic        IMemReq;
   logic        IMemAck = 1'b0;
   logic [31:0] InstrIn = '0;
   logic [31:0] InstrReg;
   logic        RegWriteControl = 1'b0;
   logic        RAMWriteControl = 1'b0;
   logic        RAMRead = 1'b0;
   logic        TestBranch = 1'b0;
   logic        AlwaysBranch = 1'b0;
   logic        BranchCond = 1'b0;
   logic        DMemReq;
   logic        DMemWe;
   logic        DMemAck = 1'b0;
   logic        RegWriteEn;
   logic        PCUpdate;
   logic        PCTakeBranch;
   logic        BusFault;
   logic [2:0]  State;
`ifdef SEQ_RETIRE_COUNT_EN
   logic [31:0] retire_count;
`endif

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_retired = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   core_sequencer_r32i #(.dataW(32), .MaxWait(MAX_WAIT)) dut (
      .clk             (clk),
      .reset           (reset),
      .RunEnable       (RunEnable),
      .IMemReq         (IMemReq),
      .IMemAck         (IMemAck),
      .InstrIn         (InstrIn),
      .InstrReg        (InstrReg),
      .RegWriteControl (RegWriteControl),
      .RAMWriteControl (RAMWriteControl),
      .RAMRead         (RAMRead),
      .TestBranch      (TestBranch),
      .AlwaysBranch    (AlwaysBranch),
      .BranchCond      (BranchCond),
      .DMemReq         (DMemReq),
      .DMemWe          (DMemWe),
      .DMemAck         (DMemAck),
      .RegWriteEn      (RegWriteEn),
      .PCUpdate        (PCUpdate),
      .PCTakeBranch    (PCTakeBranch),
      .BusFault        (BusFault),
`ifdef SEQ_RETIRE_COUNT_EN
      .RetireCount     (retire_count),
`endif
      .State           (State)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sel_sig(input int sel);
      case (sel)
         0:       return IMemReq;
         1:       return DMemReq;
         default: return PCUpdate;
      endcase
   endfunction

   task automatic wait_high(input int sel, input string name);
      for (int n = 0; n < 50; n++) begin
         if (sel_sig(sel)) return;
         tick();
      end
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out after 50 cycles", name);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_strobes"},
            32'({IMemReq, DMemReq, DMemWe, RegWriteEn, PCUpdate, PCTakeBranch, BusFault}), 32'd0);
      check({name, "_state"}, 32'(State), 32'd0);
      check({name, "_instr_reg"}, InstrReg, 32'd0);
   endtask

   // Decoder-flag image and expected retire behaviour for one instruction class.
   task automatic issue(input iclass_t c, input bit cond, input int di, input int dd,
                        output bit is_mem);
      exp_t e;
      RegWriteControl = (c == C_ALU) || (c == C_LOAD) || (c == C_JAL);
      RAMReadFlags(c);
      RAMWriteControl = (c == C_STORE);
      TestBranch      = (c == C_BRANCH);
      AlwaysBranch    = (c == C_JAL);
      BranchCond      = cond;
      case (c)
         C_ALU:    e.instr = 32'h0050_0093;  // addi x1, x0, 5
         C_LOAD:   e.instr = 32'h0040_a103;  // lw   x2, 4(x1)
         C_STORE:  e.instr = 32'h0011_2223;  // sw   x1, 4(x2)
         C_BRANCH: e.instr = 32'h0020_8463;  // beq  x1, x2, 8
         C_JAL:    e.instr = 32'h0080_00ef;  // jal  x1, 8
         default:  e.instr = 32'hffff_ffff;  // unknown opcode
      endcase
      e.reg_we     = (c == C_ALU) || (c == C_LOAD) || (c == C_JAL);
      e.is_mem     = (c == C_LOAD) || (c == C_STORE);
      e.we         = (c == C_STORE);
      e.take       = (c == C_JAL) || ((c == C_BRANCH) && cond);
      e.mem_cycles = e.is_mem ? 1 + dd : 0;
      e.cycles     = 4 + di + e.mem_cycles;
      is_mem       = e.is_mem;
      exp_q.push_back(e);
      InstrIn      = e.instr;
   endtask

   task automatic RAMReadFlags(input iclass_t c);
      RAMRead = (c == C_LOAD) || (c == C_STORE);
   endtask

   // ---------------- monitor ----------------
   initial begin
      bit   in_instr = 0;
      int   cyc = 0;
      int   memc = 0;
      bit   we_all = 1;
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            in_instr = 0;
         end else begin
            if (IMemReq && !in_instr) begin
               in_instr = 1;
               cyc      = 0;
               memc     = 0;
               we_all   = 1;
            end
            if (in_instr) begin
               cyc++;
               if (DMemReq) begin
                  memc++;
                  we_all &= DMemWe;
               end
               if (PCUpdate) begin
                  in_instr = 0;
                  n_retired++;
                  if (exp_q.size() == 0) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL unexpected_retire: retire with empty scoreboard");
                  end else begin
                     e = exp_q.pop_front();
                     check("instr_reg",     InstrReg,            e.instr);
                     check("reg_write_en",  32'(RegWriteEn),     32'(e.reg_we));
                     check("pc_take",       32'(PCTakeBranch),   32'(e.take));
                     check("instr_cycles",  32'(cyc),            32'(e.cycles));
                     check("mem_cycles",    32'(memc),           32'(e.mem_cycles));
                     if (e.is_mem) check("dmem_we", 32'(we_all), 32'(e.we));
                  end
               end
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      bit      is_mem;
      bit      drop_run;
      int      di, dd, n;
      iclass_t c;

      repeat (2) @(posedge clk);
      #1;
      check_all_zero("in_reset");

      reset     = 1'b0;
      RunEnable = 1'b1;
      check_all_zero("after_release");

      // Directed ADDI first, zero-wait fetch; then a random stream.
      for (int i = 0; i < 60; i++) begin
         if (i == 0) begin
            c  = C_ALU;
            di = 0;
            dd = 0;
         end else begin
            c  = iclass_t'($urandom_range(0, 5));
            di = $urandom_range(0, MAX_WAIT);
            dd = $urandom_range(0, MAX_WAIT);
         end
         drop_run  = (i != 0) && ($urandom_range(0, 5) == 0);
         RunEnable = 1'b1;
         issue(c, 1'($urandom_range(0, 1)), di, dd, is_mem);

         wait_high(0, "fetch_req");
         repeat (di) tick();
         IMemAck = 1'b1;
         tick();
         IMemAck = 1'b0;
         InstrIn = $urandom;
         if (drop_run) RunEnable = 1'b0;

         if (is_mem) begin
            wait_high(1, "dmem_req");
            repeat (dd) tick();
            DMemAck = 1'b1;
            tick();
            DMemAck = 1'b0;
         end
         wait_high(2, "retire");
         tick();
         if (drop_run) check("idle_after_stop", 32'(State), 32'd0);
      end

      tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef SEQ_RETIRE_COUNT_EN
      check("retire_count", retire_count, 32'(n_retired));
`endif

      // Asynchronous reset in the middle of a stalled store.
      RunEnable       = 1'b1;
      RegWriteControl = 1'b0;
      RAMWriteControl = 1'b1;
      RAMRead         = 1'b1;
      TestBranch      = 1'b0;
      AlwaysBranch    = 1'b0;
      wait_high(0, "rst_fetch_req");
      IMemAck = 1'b1;
      tick();
      IMemAck = 1'b0;
      wait_high(1, "rst_dmem_req");
      tick();
      check("mem_stalled_req", 32'(DMemReq), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("rst_dmem_req_drop", 32'(DMemReq), 32'd0);
      check("rst_state_idle",    32'(State),   32'd0);
      RunEnable = 1'b0;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         DMemAck = (k == 1);
         tick();
         check("idle_hold_state", 32'(State), 32'd0);
         check("idle_hold_dreq",  32'(DMemReq), 32'd0);
      end
      DMemAck = 1'b0;

      // Fetch timeout: ack never comes.
      RunEnable = 1'b1;
      wait_high(0, "to_fetch_req");
      n = 0;
      while (IMemReq && n < 20) begin
         n++;
         tick();
      end
      check("fetch_cycles_to_fault", 32'(n), 32'(MAX_WAIT + 1));
      check("fault_state",   32'(State),    32'd6);
      check("fault_flag",    32'(BusFault), 32'd1);
      IMemAck = 1'b1;
      repeat (4) tick();
      IMemAck   = 1'b0;
      RunEnable = 1'b0;
      tick();
      check("fault_sticky",  32'(BusFault), 32'd1);
      check("fault_no_ireq", 32'(IMemReq),  32'd0);
      reset = 1'b1;
      #1;
      check("fault_cleared", 32'(BusFault), 32'd0);
      check("fault_rst_state", 32'(State), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_core_sequencer_r32i
